// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Iterative AES-128 key expansion. A 128-bit cipher key is captured on
//   start and the round keys 0..NUM_ROUNDS are presented one at a time on a
//   valid/ready interface. Each transfer computes the next key combinationally,
//   so a consumer that is always ready receives one new key per cycle.
//   All 128-bit buses are big-endian: [0:7] is byte 0 and [0:31] is word w0.
//
// Ports
//   clk        in   1    clock, all logic on posedge
//   rst        in   1    synchronous active-high reset
//   start      in   1    request expansion of key_in (sampled only while idle)
//   key_in     in   128  cipher key, captured on the cycle start is accepted
//   busy       out  1    expansion in progress
//   rk_valid   out  1    round_key / rk_idx hold a valid round key
//   rk_ready   in   1    consumer accepts the presented key
//   rk_idx     out  4    index of the presented round key
//   round_key  out  128  presented round key
//   done       out  1    one-cycle pulse after the last key is transferred
//
// States
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; round_key/rk_idx keep their last values
//   ST_GEN   | presenting round key rk_idx, advancing on each transfer
// ---------------------------------------------------------------------------
module aes_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_idx,
    output logic [0:127] round_key,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // Forward AES S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [0:127] round_key_q, round_key_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [0:31]  w0, w1, w2, w3;
    logic [0:31]  rot_w3, sub_w3, t_word;
    logic [0:31]  n0, n1, n2, n3;
    logic [0:127] next_key;

    // Byte-wise substitution of one 32-bit word (SubWord), byte 0 at [0:7].
    function automatic logic [0:31] sub_word(input logic [0:31] w);
        return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
    endfunction

    // Multiply by x in GF(2^8); walks the Rcon sequence 01,02,..,80,1B,36.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Next-key datapath, evaluated every cycle from the presented key so the
    // following key is ready in the same cycle as the transfer.
    assign w0       = round_key_q[0:31];
    assign w1       = round_key_q[32:63];
    assign w2       = round_key_q[64:95];
    assign w3       = round_key_q[96:127];
    assign rot_w3   = {w3[8:31], w3[0:7]};
    assign sub_w3   = sub_word(rot_w3);
    assign t_word   = sub_w3 ^ {rcon_q, 24'h0};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        rk_idx_d    = rk_idx_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_GEN;
                    round_key_d = key_in;
                    rk_idx_d    = 4'd0;
                    rcon_d      = 8'h01;
                end
            end
            ST_GEN: begin
                if (rk_ready) begin
                    if (rk_idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rk_idx_d    = rk_idx_q + 4'd1;
                        round_key_d = next_key;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            rk_idx_q    <= 4'd0;
            rcon_q      <= 8'h01;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            rk_idx_q    <= rk_idx_d;
            rcon_q      <= rcon_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == ST_GEN);
    assign rk_valid  = (state_q == ST_GEN);
    assign rk_idx    = rk_idx_q;
    assign round_key = round_key_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
//   Two instances (NUM_ROUNDS=10 and NUM_ROUNDS=4) checked every cycle
//   against a transaction-level model that precomputes the whole key schedule
//   from the standard word recursion with an S-box derived from GF(2^8)
//   inversion. Directed scenarios plus randomized traffic.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_F1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_F10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_Z1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K_Z10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] K_OTHER = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk;
    logic         rst;
    logic         start0, start1;
    logic [127:0] key0, key1;
    logic         ready0, ready1;
    logic         busy0, busy1, valid0, valid1, done0, done1;
    logic [3:0]   idx0, idx1;
    logic [127:0] rkey0, rkey1;

    aes_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start0), .key_in(key0), .busy(busy0),
        .rk_valid(valid0), .rk_ready(ready0), .rk_idx(idx0), .round_key(rkey0), .done(done0)
    );

    aes_key_schedule #(.NUM_ROUNDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start1), .key_in(key1), .busy(busy1),
        .rk_valid(valid1), .rk_ready(ready1), .rk_idx(idx1), .round_key(rkey1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // m_keys[inst][k]: full schedule for the run in progress; inst 2 is scratch.
    logic [127:0] m_keys [3][11];

    task automatic build(input int inst, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++)
            m_keys[inst][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    logic         m_busy [2];
    logic [3:0]   m_idx  [2];
    logic [127:0] m_key  [2];
    logic         m_done [2];

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            logic st, rdy;
            logic [127:0] kin;
            int last;
            st   = (n == 0) ? start0 : start1;
            rdy  = (n == 0) ? ready0 : ready1;
            kin  = (n == 0) ? key0 : key1;
            last = (n == 0) ? 10 : 4;
            if (rst) begin
                m_busy[n] = 1'b0; m_idx[n] = 4'd0; m_key[n] = '0; m_done[n] = 1'b0;
            end else begin
                m_done[n] = 1'b0;
                if (!m_busy[n]) begin
                    if (st) begin
                        build(n, kin);
                        m_busy[n] = 1'b1; m_idx[n] = 4'd0; m_key[n] = m_keys[n][0];
                    end
                end else if (rdy) begin
                    if (int'(m_idx[n]) == last) begin
                        m_busy[n] = 1'b0; m_done[n] = 1'b1;
                    end else begin
                        m_idx[n] = m_idx[n] + 4'd1;
                        m_key[n] = m_keys[n][m_idx[n]];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int max_idx1  = 0;
    int done1_cnt = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("i0_busy",  busy0,  m_busy[0]);
            chk("i0_valid", valid0, m_busy[0]);
            chk("i0_done",  done0,  m_done[0]);
            chk("i0_idx",   idx0,   m_idx[0]);
            chk("i0_key",   rkey0,  m_key[0]);
            chk("i1_busy",  busy1,  m_busy[1]);
            chk("i1_valid", valid1, m_busy[1]);
            chk("i1_done",  done1,  m_done[1]);
            chk("i1_idx",   idx1,   m_idx[1]);
            chk("i1_key",   rkey1,  m_key[1]);
            if (valid1 && int'(idx1) > max_idx1) max_idx1 = int'(idx1);
            if (done1) done1_cnt++;
        end
    end

    // NUM_ROUNDS=4 instance runs random traffic for the whole test.
    initial begin
        start1 = 1'b0; key1 = '0; ready1 = 1'b1;
        forever begin
            @(negedge clk);
            start1 = ($urandom_range(0, 3) == 0);
            key1   = {$urandom, $urandom, $urandom, $urandom};
            ready1 = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- directed + random stimulus (instance 0) ----------------
    task automatic wait_idx(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(valid0 && idx0 == target) && n < 60);
        chk({tag, "_reached"}, (valid0 && idx0 == target), 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 60);
        chk({tag, "_done"}, done0, 1'b1);
    endtask

    task automatic pulse_start(input logic [127:0] key);
        start0 = 1'b1;
        key0   = key;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    initial begin
        int k;
        logic [127:0] held_key;
        build_sbox();
        rst = 1'b1; start0 = 1'b0; key0 = '0; ready0 = 1'b1;
        @(posedge clk);
        armed = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_idx", idx0, 4'd0);
        chk("reset_key", rkey0, 128'h0);
        rst = 1'b0;

        // Pin the model to published vectors.
        build(2, K_FIPS);
        chk("model_fips_idx1",  m_keys[2][1],  K_F1);
        chk("model_fips_idx10", m_keys[2][10], K_F10);
        build(2, '0);
        chk("model_zero_idx0",  m_keys[2][0],  128'h0);
        chk("model_zero_idx1",  m_keys[2][1],  K_Z1);
        chk("model_zero_idx10", m_keys[2][10], K_Z10);

        // FIPS-197 key, always ready; done 12 cycles after the start cycle.
        @(negedge clk);
        start0 = 1'b1; key0 = K_FIPS; ready0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 1;
        while (!done0 && k < 20) begin
            if (valid0 && idx0 == 4'd1)  chk("fips_idx1",  rkey0, K_F1);
            if (valid0 && idx0 == 4'd10) chk("fips_idx10", rkey0, K_F10);
            @(negedge clk);
            k++;
        end
        chk("fips_done_cycle", k, 12);

        // All-zero key.
        @(negedge clk);
        start0 = 1'b1; key0 = '0;
        @(negedge clk);
        start0 = 1'b0;
        chk("zero_idx0", rkey0, 128'h0);
        @(negedge clk);
        chk("zero_idx1", rkey0, K_Z1);
        wait_idx(4'd10, "zero10");
        chk("zero_idx10", rkey0, K_Z10);
        wait_done("zero");

        // Backpressure at idx3 for 5 cycles.
        build(2, K_FIPS);
        @(negedge clk);
        pulse_start(K_FIPS);
        wait_idx(4'd3, "bp3");
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_idx_hold", idx0, 4'd3);
            chk("bp_key_hold", rkey0, m_keys[2][3]);
            chk("bp_valid_hold", valid0, 1'b1);
        end
        ready0 = 1'b1;
        wait_idx(4'd10, "bp10");
        chk("bp_idx10", rkey0, K_F10);
        wait_done("bp");

        // start while busy is ignored.
        @(negedge clk);
        pulse_start(K_FIPS);
        wait_idx(4'd5, "ign5");
        pulse_start(K_OTHER);
        wait_idx(4'd10, "ign10");
        chk("ign_idx10", rkey0, K_F10);
        wait_done("ign");

        // Reset mid-expansion, then restart.
        @(negedge clk);
        pulse_start(K_FIPS);
        wait_idx(4'd6, "rst6");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", valid0, 1'b0);
        chk("rst_busy",  busy0,  1'b0);
        chk("rst_idx",   idx0,   4'd0);
        chk("rst_key",   rkey0,  128'h0);
        chk("rst_done",  done0,  1'b0);
        rst = 1'b0;
        pulse_start('0);
        chk("restart_valid", valid0, 1'b1);
        chk("restart_idx",   idx0,   4'd0);
        wait_done("restart");

        // start held across done: back-to-back expansion.
        @(negedge clk);
        start0 = 1'b1; key0 = K_FIPS;
        wait_done("b2b_first");
        @(negedge clk);
        chk("b2b_valid", valid0, 1'b1);
        chk("b2b_idx",   idx0,   4'd0);
        chk("b2b_key",   rkey0,  K_FIPS);
        start0 = 1'b0;
        wait_done("b2b_second");

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start0 = ($urandom_range(0, 4) == 0);
            key0   = {$urandom, $urandom, $urandom, $urandom};
            ready0 = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0; ready0 = 1'b1;
        held_key = '0;
        repeat (30) @(negedge clk);

        chk("dut4_max_idx", max_idx1, 4);
        chk("dut4_done_seen", (done1_cnt > 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
